// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one single-port memory bus between instruction fetch and data access.
// Data wins ties; a streak counter forces a waiting fetch through, and a watchdog aborts hung transactions.
module imem_dmem_arbiter #(
    parameter int MAX_DM_STREAK = 4,
    parameter int TIMEOUT       = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    // fetch port
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_kill,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    // data port
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_be,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ready,
    output logic [31:0] dm_rdata,
    // memory bus
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        bus_err,
    // debug view of the arbiter state
    output logic [1:0]  dbg_state_o
);

    // Handshake: a requester raises req with stable qualifiers and holds them
    // until its ready pulses for one cycle; ready and rdata are valid in that cycle only.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic        kill_q;
    logic [3:0]  streak_q;
    logic [7:0]  tmo_q;
    logic        mem_we_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    logic busy;
    logic tmo_hit;
    logic done;
    logic grant_if;
    logic grant_dm;

    assign busy     = (state_q != IDLE);
    assign tmo_hit  = busy && !mem_ack && (tmo_q == TMO_LAST);
    assign done     = busy && (mem_ack || tmo_hit);
    assign grant_if = !busy && if_req && (!dm_req || (streak_q == STREAK_MAX));
    assign grant_dm = !busy && dm_req && !grant_if;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            kill_q      <= 1'b0;
            streak_q    <= '0;
            tmo_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    tmo_q  <= '0;
                    kill_q <= 1'b0;
                    if (grant_if) begin
                        state_q     <= BUSY_IF;
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= 4'hF;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= '0;
                        streak_q    <= '0;
                    end else if (grant_dm) begin
                        state_q     <= BUSY_DM;
                        mem_we_q    <= dm_we;
                        mem_be_q    <= dm_be;
                        mem_addr_q  <= dm_addr;
                        mem_wdata_q <= dm_wdata;
                        if (if_req && (streak_q != STREAK_MAX)) begin
                            streak_q <= streak_q + 4'd1;
                        end
                    end
                    // a fetch that is not waiting has nothing to be starved of
                    if (!if_req) begin
                        streak_q <= '0;
                    end
                end
                default: begin
                    if (done) begin
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                    if ((state_q == BUSY_IF) && if_kill) begin
                        kill_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Completion is combinational so the pipeline sees read data in the ack cycle.
    assign if_ready    = (state_q == BUSY_IF) && done && !kill_q && !if_kill;
    assign dm_ready    = (state_q == BUSY_DM) && done;
    assign if_rdata    = (if_ready && mem_ack) ? mem_rdata : '0;
    assign dm_rdata    = (dm_ready && mem_ack) ? mem_rdata : '0;
    assign bus_err     = tmo_hit;

    assign mem_req     = busy;
    assign mem_we      = mem_we_q;
    assign mem_be      = mem_be_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Randomized bench for imem_dmem_arbiter: two requester drivers, a memory responder,
// and a monitor that scores completions against expected queues and a grant-order model.
module tb_imem_dmem_arbiter;

    localparam int MAX_DM_STREAK = 4;
    localparam int TIMEOUT       = 8;
    localparam int N_FETCH       = 150;
    localparam int N_DATA        = 150;
    localparam int WAIT_LIMIT    = 120;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req, if_kill, if_ready;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_ready;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_req, mem_we, mem_ack, bus_err;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    imem_dmem_arbiter #(.MAX_DM_STREAK(MAX_DM_STREAK), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_ready(if_ready), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .bus_err(bus_err), .dbg_state_o(dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // {rdata_dont_care, bus_err, rdata}
    logic [33:0] if_exp_q[$];
    logic [33:0] dm_exp_q[$];

    logic [31:0] bus_mem[16];
    logic [31:0] ref_mem[16];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Instruction memory is read-only and defined by address.
    function automatic logic [31:0] instr_at(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // ---------------- memory responder ----------------
    int unsigned wait_cnt = 0;
    int unsigned delay    = 0;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!reset_n || !mem_req) begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                wait_cnt  = 0;
            end else begin
                if (wait_cnt == 0) begin
                    delay = $urandom_range(0, 4);
                    if (delay == 4) delay = TIMEOUT - 1;
                end
                if (wait_cnt == delay && mem_addr[31:28] != 4'hF) begin
                    mem_ack = 1'b1;
                    if (mem_addr[16]) begin
                        if (mem_we) begin
                            for (int b = 0; b < 4; b++)
                                if (mem_be[b]) bus_mem[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                            mem_rdata = $urandom;
                        end else begin
                            mem_rdata = bus_mem[mem_addr[5:2]];
                        end
                    end else begin
                        mem_rdata = instr_at(mem_addr);
                    end
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                end
                wait_cnt++;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic        prev_busy = 1'b0, prev_idle_req = 1'b0;
    logic        pend_if = 1'b0, pend_dm = 1'b0, cur_fetch = 1'b0, exp_fetch;
    logic [31:0] cap_if_addr, cap_dm_addr, cap_dm_wdata, q_addr, q_wdata;
    logic [3:0]  cap_dm_be, q_be;
    logic        cap_dm_we, q_we;
    int          dm_wins = 0, busy_cnt = 0;
    logic [33:0] e;

    always @(negedge clk) begin
        if (!reset_n) begin
            dm_wins       = 0;
            prev_busy     = 1'b0;
            prev_idle_req = 1'b0;
        end else begin
            if (prev_idle_req) check("grant_after_request", mem_req, 1);
            if (!mem_req) begin
                check("idle_ready_err", {if_ready, dm_ready, bus_err}, 0);
                check("idle_rdata", {if_rdata, dm_rdata}, 0);
                if (!if_req) dm_wins = 0;
                pend_if       = if_req;
                pend_dm       = dm_req;
                cap_if_addr   = if_addr;
                cap_dm_addr   = dm_addr;
                cap_dm_we     = dm_we;
                cap_dm_be     = dm_be;
                cap_dm_wdata  = dm_wdata;
                prev_idle_req = if_req || dm_req;
            end else begin
                prev_idle_req = 1'b0;
                if (!prev_busy) begin
                    check("spurious_grant", pend_if || pend_dm, 1);
                    exp_fetch = pend_if && (!pend_dm || dm_wins >= MAX_DM_STREAK);
                    cur_fetch = exp_fetch;
                    if (exp_fetch) begin
                        check("fetch_grant_addr", mem_addr, cap_if_addr);
                        check("fetch_grant_quals", {mem_we, mem_be, mem_wdata}, {1'b0, 4'hF, 32'h0});
                        dm_wins = 0;
                    end else begin
                        check("data_grant_addr", mem_addr, cap_dm_addr);
                        check("data_grant_quals", {mem_we, mem_be, mem_wdata},
                              {cap_dm_we, cap_dm_be, cap_dm_wdata});
                        if (pend_if && dm_wins < MAX_DM_STREAK) dm_wins++;
                    end
                    q_addr   = mem_addr;
                    q_we     = mem_we;
                    q_be     = mem_be;
                    q_wdata  = mem_wdata;
                    busy_cnt = 0;
                end else begin
                    check("quals_stable", {mem_we, mem_be, mem_wdata}, {q_we, q_be, q_wdata});
                    check("addr_stable", mem_addr, q_addr);
                end
                busy_cnt++;
                if (bus_err) begin
                    check("timeout_cycle", busy_cnt, TIMEOUT);
                    check("timeout_no_ack", mem_ack, 0);
                end
                if (if_ready) begin
                    check("if_ready_kind", cur_fetch, 1);
                    if (if_exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_if_ready: got 1 expected 0 at %0t", $time);
                    end else begin
                        e = if_exp_q.pop_front();
                        check("if_rdata", if_rdata, e[31:0]);
                        check("if_bus_err", bus_err, e[32]);
                    end
                end else begin
                    check("if_rdata_zero", if_rdata, 0);
                end
                if (dm_ready) begin
                    check("dm_ready_kind", cur_fetch, 0);
                    if (dm_exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_dm_ready: got 1 expected 0 at %0t", $time);
                    end else begin
                        e = dm_exp_q.pop_front();
                        if (!e[33]) check("dm_rdata", dm_rdata, e[31:0]);
                        check("dm_bus_err", bus_err, e[32]);
                    end
                end else begin
                    check("dm_rdata_zero", dm_rdata, 0);
                end
                if (bus_err && !if_ready && !dm_ready) begin
                    checks++; errors++;
                    $display("FAIL bus_err_without_ready: got 0 expected 1 at %0t", $time);
                end
            end
            prev_busy = mem_req;
        end
    end

    // ---------------- drivers ----------------
    task automatic fetch_driver();
        for (int n = 0; n < N_FETCH; n++) begin
            logic        kill;
            logic        dead;
            logic        done;
            logic [31:0] addr;
            int          cnt;
            int          idle;
            idle = $urandom_range(0, 2);
            for (int k = 0; k < idle; k++) begin @(posedge clk); #1; end
            kill = ($urandom_range(0, 6) == 0);
            dead = !kill && ($urandom_range(0, 9) == 0);
            addr = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            if (dead) addr = addr | 32'hF000_0000;
            if (!kill) if_exp_q.push_back({1'b0, dead, dead ? 32'h0 : instr_at(addr)});
            if_addr = addr;
            if_req  = 1'b1;
            cnt     = 0;
            done    = 1'b0;
            while (!done) begin
                if (kill && mem_req && mem_addr == addr && !mem_we) begin
                    if_kill = 1'b1;
                    @(posedge clk); #1;
                    if_kill = 1'b0;
                    if_req  = 1'b0;
                    while (mem_req && cnt < WAIT_LIMIT) begin @(posedge clk); #1; cnt++; end
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                    if (if_ready) done = 1'b1;
                    @(posedge clk); #1;
                    cnt++;
                end
                if (cnt >= WAIT_LIMIT) begin
                    checks++; errors++;
                    $display("FAIL fetch_wait: got no completion expected within %0d cycles at %0t", WAIT_LIMIT, $time);
                    done = 1'b1;
                end
            end
            if_req = 1'b0;
        end
    endtask

    task automatic dm_driver();
        for (int n = 0; n < N_DATA; n++) begin
            logic        store;
            logic        dead;
            logic        done;
            logic [3:0]  idx;
            logic [3:0]  be;
            logic [31:0] addr;
            logic [31:0] wdata;
            int          cnt;
            int          idle;
            idle = $urandom_range(0, 2);
            for (int k = 0; k < idle; k++) begin @(posedge clk); #1; end
            idx   = 4'($urandom_range(0, 15));
            store = 1'($urandom_range(0, 1));
            dead  = ($urandom_range(0, 9) == 0);
            addr  = (dead ? 32'hF001_0000 : 32'h0001_0000) | {26'h0, idx, 2'b00};
            be    = store ? 4'($urandom_range(1, 15)) : 4'hF;
            wdata = $urandom;
            if (store) begin
                dm_exp_q.push_back({1'b1, dead, 32'h0});
                if (!dead)
                    for (int b = 0; b < 4; b++)
                        if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                dm_exp_q.push_back({1'b0, dead, dead ? 32'h0 : ref_mem[idx]});
            end
            dm_addr  = addr;
            dm_we    = store;
            dm_be    = be;
            dm_wdata = wdata;
            dm_req   = 1'b1;
            cnt      = 0;
            done     = 1'b0;
            while (!done) begin
                @(negedge clk);
                if (dm_ready) done = 1'b1;
                @(posedge clk); #1;
                cnt++;
                if (!done && cnt >= WAIT_LIMIT) begin
                    checks++; errors++;
                    $display("FAIL data_wait: got no completion expected within %0d cycles at %0t", WAIT_LIMIT, $time);
                    done = 1'b1;
                end
            end
            dm_req = 1'b0;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset_n  = 1'b0;
        if_req   = 1'b0; if_addr = '0; if_kill = 1'b0;
        dm_req   = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
        for (int i = 0; i < 16; i++) begin
            bus_mem[i] = 32'hA500_0000 | (i * 32'h0101);
            ref_mem[i] = 32'hA500_0000 | (i * 32'h0101);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_mem_req", mem_req, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_bus_quals", {mem_we, mem_be, mem_wdata}, 0);
        check("reset_ready_err", {if_ready, dm_ready, bus_err}, 0);
        check("reset_rdata", {if_rdata, dm_rdata}, 0);
        check("reset_state", dbg_state, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Reset in the middle of a data access that memory never answers.
        dm_addr = 32'hF001_0004; dm_we = 1'b0; dm_be = 4'hF; dm_wdata = '0;
        dm_req  = 1'b1;
        @(posedge clk); #1;
        check("busy_before_reset", mem_req, 1);
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset_mem_req", mem_req, 0);
        check("async_reset_state", dbg_state, 0);
        dm_req = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        fork
            fetch_driver();
            dm_driver();
        join
        repeat (20) @(posedge clk);
        check("if_queue_drained", if_exp_q.size(), 0);
        check("dm_queue_drained", dm_exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got no finish expected before %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
